// File: rtl/id_ex_pkg.sv
// Shared types for the decode-to-execute stage: packed control bus,
// the PC register index, and the operand forwarding source selector.
package id_ex_pkg;

    localparam int unsigned CTRL_W = 13;
    localparam logic [3:0]  R15    = 4'hF;

    typedef struct packed {
        logic       RegWrite;
        logic       MemToReg;
        logic       MemWrite;
        logic       ALUSrc;
        logic [1:0] ALUControl;
        logic [1:0] FlagWrite;
        logic       Branch;
        logic [3:0] Cond;
    } ctrl_t;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_W  = 2'd1,
        FWD_M  = 2'd2
    } fwd_sel_t;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Single-operand forwarding selector: Memory beats Writeback, and the
// PC register (all-ones address) always comes from the register file.
module fwd_mux
    import id_ex_pkg::*;
#(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 4
) (
    input  logic [AW-1:0] i_ra,
    input  logic [DW-1:0] i_rd,
    input  logic          i_we_m,
    input  logic [AW-1:0] i_wa_m,
    input  logic [DW-1:0] i_res_m,
    input  logic          i_we_w,
    input  logic [AW-1:0] i_wa_w,
    input  logic [DW-1:0] i_res_w,
    output logic [DW-1:0] o_data
);

    fwd_sel_t w_sel;

    always_comb begin
        w_sel = FWD_RF;
        if (i_ra != '1) begin
            if (i_we_m && (i_wa_m == i_ra)) begin
                w_sel = FWD_M;
            end else if (i_we_w && (i_wa_w == i_ra)) begin
                w_sel = FWD_W;
            end
        end
    end

    always_comb begin
        unique case (w_sel)
            FWD_M:   o_data = i_res_m;
            FWD_W:   o_data = i_res_w;
            default: o_data = i_rd;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with M/W operand forwarding,
// load-use stall / redirect flush generation and saturating event counters.
module id_ex_stage
    import id_ex_pkg::*;
#(
    parameter int unsigned DW     = 32,
    parameter int unsigned AW     = 4,
    parameter int unsigned CTRL_W = id_ex_pkg::CTRL_W,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              ValidD,
    input  logic [AW-1:0]     RA1D,
    input  logic [AW-1:0]     RA2D,
    input  logic [AW-1:0]     WA3D,
    input  logic [DW-1:0]     RD1D,
    input  logic [DW-1:0]     RD2D,
    input  logic [DW-1:0]     ImmD,
    input  logic [CTRL_W-1:0] CtrlD,
    input  logic              RegWriteM,
    input  logic [AW-1:0]     WA3M,
    input  logic [DW-1:0]     ALUResultM,
    input  logic              RegWriteW,
    input  logic [AW-1:0]     WA3W,
    input  logic [DW-1:0]     ResultW,
    input  logic              PCSrcE,
    output logic              ValidE,
    output logic [CTRL_W-1:0] CtrlE,
    output logic [AW-1:0]     WA3E,
    output logic [DW-1:0]     ImmE,
    output logic [DW-1:0]     SrcAE,
    output logic [DW-1:0]     WriteDataE,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushD,
    output logic [CNT_W-1:0]  StallCnt,
    output logic [CNT_W-1:0]  FlushCnt
);

    logic             r_valid_e;
    ctrl_t            r_ctrl_e;
    logic [AW-1:0]    r_wa3_e;
    logic [DW-1:0]    r_imm_e;
    logic [AW-1:0]    r_ra1_e;
    logic [AW-1:0]    r_ra2_e;
    logic [DW-1:0]    r_rd1_e;
    logic [DW-1:0]    r_rd2_e;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_hit1;
    logic w_hit2;
    logic w_ld_stall;
    logic w_stall;

    // A load in E whose result a valid D instruction needs; R15 reads never depend on it.
    assign w_hit1     = (RA1D != '1) && (RA1D == r_wa3_e);
    assign w_hit2     = (RA2D != '1) && (RA2D == r_wa3_e);
    assign w_ld_stall = r_valid_e && r_ctrl_e.RegWrite && r_ctrl_e.MemToReg &&
                        ValidD && (w_hit1 || w_hit2);
    assign w_stall    = w_ld_stall && !PCSrcE;

    assign StallF = w_stall;
    assign StallD = w_stall;
    assign FlushD = PCSrcE;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_valid_e <= 1'b0;
            r_ctrl_e  <= '0;
            r_wa3_e   <= '0;
            r_imm_e   <= '0;
            r_ra1_e   <= '0;
            r_ra2_e   <= '0;
            r_rd1_e   <= '0;
            r_rd2_e   <= '0;
        end else begin
            r_wa3_e <= WA3D;
            r_imm_e <= ImmD;
            r_ra1_e <= RA1D;
            r_ra2_e <= RA2D;
            r_rd1_e <= RD1D;
            r_rd2_e <= RD2D;
            if (PCSrcE || w_ld_stall) begin
                r_valid_e <= 1'b0;
                r_ctrl_e  <= '0;
            end else begin
                r_valid_e <= ValidD;
                r_ctrl_e  <= ValidD ? ctrl_t'(CtrlD) : '0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (PCSrcE && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    fwd_mux #(
        .DW (DW),
        .AW (AW)
    ) u_fwd_a (
        .i_ra    (r_ra1_e),
        .i_rd    (r_rd1_e),
        .i_we_m  (RegWriteM),
        .i_wa_m  (WA3M),
        .i_res_m (ALUResultM),
        .i_we_w  (RegWriteW),
        .i_wa_w  (WA3W),
        .i_res_w (ResultW),
        .o_data  (SrcAE)
    );

    fwd_mux #(
        .DW (DW),
        .AW (AW)
    ) u_fwd_b (
        .i_ra    (r_ra2_e),
        .i_rd    (r_rd2_e),
        .i_we_m  (RegWriteM),
        .i_wa_m  (WA3M),
        .i_res_m (ALUResultM),
        .i_we_w  (RegWriteW),
        .i_wa_w  (WA3W),
        .i_res_w (ResultW),
        .o_data  (WriteDataE)
    );

    assign ValidE   = r_valid_e;
    assign CtrlE    = r_ctrl_e;
    assign WA3E     = r_wa3_e;
    assign ImmE     = r_imm_e;
    assign StallCnt = r_stall_cnt;
    assign FlushCnt = r_flush_cnt;

endmodule
